// File: rtl/cond_unit_if.sv
// Controller-facing bundle of the condition unit: instruction/ALU inputs
// and the predicated write enables and status it returns.
interface cond_unit_if #(
  parameter int BANKW = 1,
  parameter int CNTW  = 16
);
  logic [3:0]       i_cond;
  logic [3:0]       i_aluFlags;
  logic [1:0]       i_flagW;
  logic [BANKW-1:0] i_bank;
  logic             i_condLatch;
  logic             i_pcs;
  logic             i_nextPc;
  logic             i_regW;
  logic             i_memW;
  logic             o_pcWrite;
  logic             o_regWrite;
  logic             o_memWrite;
  logic             o_condExQ;
  logic [3:0]       o_flagsOut;
  logic [CNTW-1:0]  o_squashCnt;

  modport master (
    output i_cond, i_aluFlags, i_flagW, i_bank, i_condLatch,
           i_pcs, i_nextPc, i_regW, i_memW,
    input  o_pcWrite, o_regWrite, o_memWrite, o_condExQ, o_flagsOut, o_squashCnt
  );

  modport slave (
    input  i_cond, i_aluFlags, i_flagW, i_bank, i_condLatch,
           i_pcs, i_nextPc, i_regW, i_memW,
    output o_pcWrite, o_regWrite, o_memWrite, o_condExQ, o_flagsOut, o_squashCnt
  );
endinterface

// File: rtl/cond_unit.sv
// Banked NZCV flags, condition evaluation with pending-write forwarding,
// latched predicate gating the controller's write strobes, and a squash counter.
module cond_unit #(
  parameter int NBANKS      = 1,
  parameter int BANKW       = 1,
  parameter int DEFER_FLAGS = 1,
  parameter int CNTW        = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  cond_unit_if.slave bus
);

  logic [3:0]       r_flags [NBANKS];
  logic             r_condExQ;
  logic [CNTW-1:0]  r_squashCnt;
  logic             r_pendValid;
  logic [1:0]       r_pendWe;
  logic [3:0]       r_pendFlags;
  logic [BANKW-1:0] r_pendBank;

  logic [BANKW-1:0] w_bankSel;
  logic             w_bankHit;
  logic [3:0]       w_committed;
  logic [3:0]       w_ef;
  logic             w_n, w_z, w_c, w_v;
  logic             w_condEx;
  logic [1:0]       w_we;

  // A single-bank unit ignores the select so any Bank value maps to bank 0.
  assign w_bankSel = (NBANKS == 1) ? '0 : bus.i_bank;

  always_comb begin
    w_committed = 4'b0000;
    w_bankHit   = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      if (w_bankSel == BANKW'(b)) begin
        w_committed = r_flags[b];
        w_bankHit   = 1'b1;
      end
    end
  end

  always_comb begin
    w_ef = w_committed;
    if (DEFER_FLAGS != 0 && r_pendValid && r_pendBank == w_bankSel) begin
      if (r_pendWe[1]) w_ef[3:2] = r_pendFlags[3:2];
      if (r_pendWe[0]) w_ef[1:0] = r_pendFlags[1:0];
    end
  end

  assign {w_n, w_z, w_c, w_v} = w_ef;

  always_comb begin
    case (bus.i_cond)
      4'b0000: w_condEx = w_z;
      4'b0001: w_condEx = ~w_z;
      4'b0010: w_condEx = w_c;
      4'b0011: w_condEx = ~w_c;
      4'b0100: w_condEx = w_n;
      4'b0101: w_condEx = ~w_n;
      4'b0110: w_condEx = w_v;
      4'b0111: w_condEx = ~w_v;
      4'b1000: w_condEx = w_c & ~w_z;
      4'b1001: w_condEx = ~w_c | w_z;
      4'b1010: w_condEx = (w_n == w_v);
      4'b1011: w_condEx = (w_n != w_v);
      4'b1100: w_condEx = ~w_z & (w_n == w_v);
      4'b1101: w_condEx = w_z | (w_n != w_v);
      default: w_condEx = 1'b1;
    endcase
  end

  assign w_we = bus.i_flagW & {2{r_condExQ}};

  // Deferred mode commits last cycle's capture while capturing this cycle's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANKS; b++) r_flags[b] <= 4'b0000;
      r_pendValid <= 1'b0;
      r_pendWe    <= 2'b00;
      r_pendFlags <= 4'b0000;
      r_pendBank  <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        if (DEFER_FLAGS != 0) begin
          if (r_pendValid && r_pendBank == BANKW'(b)) begin
            if (r_pendWe[1]) r_flags[b][3:2] <= r_pendFlags[3:2];
            if (r_pendWe[0]) r_flags[b][1:0] <= r_pendFlags[1:0];
          end
        end else if (w_bankSel == BANKW'(b)) begin
          if (w_we[1]) r_flags[b][3:2] <= bus.i_aluFlags[3:2];
          if (w_we[0]) r_flags[b][1:0] <= bus.i_aluFlags[1:0];
        end
      end
      r_pendValid <= (DEFER_FLAGS != 0) && (|w_we) && w_bankHit;
      r_pendWe    <= w_we;
      r_pendFlags <= bus.i_aluFlags;
      r_pendBank  <= w_bankSel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_condExQ   <= 1'b0;
      r_squashCnt <= '0;
    end else if (bus.i_condLatch) begin
      r_condExQ <= w_condEx;
      if (!w_condEx && r_squashCnt != '1) r_squashCnt <= r_squashCnt + 1'b1;
    end
  end

  assign bus.o_pcWrite   = bus.i_nextPc | (bus.i_pcs & r_condExQ);
  assign bus.o_regWrite  = bus.i_regW & r_condExQ;
  assign bus.o_memWrite  = bus.i_memW & r_condExQ;
  assign bus.o_condExQ   = r_condExQ;
  assign bus.o_flagsOut  = w_committed;
  assign bus.o_squashCnt = r_squashCnt;

endmodule

// File: tb/tb_cond_unit.sv
// Drives a 4-bank deferred unit and a 1-bank immediate unit with identical
// stimulus and compares both against a flag/predicate reference model.
module tb_cond_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cond_unit_if #(.BANKW(3), .CNTW(2)) if0 ();
  cond_unit_if #(.BANKW(1), .CNTW(4)) if1 ();

  cond_unit #(.NBANKS(4), .BANKW(3), .DEFER_FLAGS(1), .CNTW(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  cond_unit #(.NBANKS(1), .BANKW(1), .DEFER_FLAGS(0), .CNTW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int assertCount = 0;
  int failCount   = 0;

  int nb[2]     = '{4, 1};
  bit deferM[2] = '{1'b1, 1'b0};
  int cntMax[2] = '{3, 15};

  logic [3:0] mFlags [2][8];
  logic       mCondQ [2];
  int         mCnt   [2];
  bit         pValid [2];
  logic [1:0] pWe    [2];
  logic [3:0] pFlags [2];
  int         pBank  [2];

  logic [3:0] sCond, sAlu;
  logic [1:0] sFlagW;
  int         sBank;
  logic       sLatch, sPcs, sNextPc, sRegW, sMemW;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] merge(input logic [3:0] old, input logic [1:0] we, input logic [3:0] nw);
    logic [3:0] r;
    r = old;
    if (we[1]) r[3:2] = nw[3:2];
    if (we[0]) r[1:0] = nw[1:0];
    return r;
  endfunction

  function automatic int modelBank(input int d);
    return (nb[d] == 1) ? 0 : sBank;
  endfunction

  function automatic logic [3:0] committedFlags(input int d);
    int b;
    b = modelBank(d);
    return (b < nb[d]) ? mFlags[d][b] : 4'b0000;
  endfunction

  function automatic logic [3:0] effectiveFlags(input int d);
    logic [3:0] f;
    f = committedFlags(d);
    if (deferM[d] && pValid[d] && pBank[d] == modelBank(d)) f = merge(f, pWe[d], pFlags[d]);
    return f;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 8; b++) mFlags[d][b] = 4'b0000;
      mCondQ[d] = 1'b0;
      mCnt[d]   = 0;
      pValid[d] = 1'b0;
      pWe[d]    = 2'b00;
      pFlags[d] = 4'b0000;
      pBank[d]  = 0;
    end
  endtask

  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      logic ce;
      logic [1:0] we;
      int b;
      ce = condHolds(sCond, effectiveFlags(d));
      we = sFlagW & {2{mCondQ[d]}};
      b  = modelBank(d);
      if (deferM[d]) begin
        if (pValid[d]) mFlags[d][pBank[d]] = merge(mFlags[d][pBank[d]], pWe[d], pFlags[d]);
        pValid[d] = (we != 2'b00) && (b < nb[d]);
        pWe[d]    = we;
        pFlags[d] = sAlu;
        pBank[d]  = b;
      end else if (b < nb[d]) begin
        mFlags[d][b] = merge(mFlags[d][b], we, sAlu);
      end
      if (sLatch) begin
        if (!ce && mCnt[d] < cntMax[d]) mCnt[d]++;
        mCondQ[d] = ce;
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] flagW,
                               input int bank, input logic latch, input logic pcs, input logic nextPc,
                               input logic regW, input logic memW);
    logic [2:0] bankBits;
    sCond = cond; sAlu = alu; sFlagW = flagW; sBank = bank; sLatch = latch;
    sPcs = pcs; sNextPc = nextPc; sRegW = regW; sMemW = memW;
    bankBits = 3'(bank);
    if0.i_cond = cond; if0.i_aluFlags = alu; if0.i_flagW = flagW; if0.i_bank = bankBits;
    if0.i_condLatch = latch; if0.i_pcs = pcs; if0.i_nextPc = nextPc; if0.i_regW = regW; if0.i_memW = memW;
    if1.i_cond = cond; if1.i_aluFlags = alu; if1.i_flagW = flagW; if1.i_bank = bankBits[0];
    if1.i_condLatch = latch; if1.i_pcs = pcs; if1.i_nextPc = nextPc; if1.i_regW = regW; if1.i_memW = memW;
  endtask

  task automatic checkDut(input int d, input logic condQ, input logic [3:0] flagsOut, input logic [31:0] cnt,
                          input logic pcw, input logic rw, input logic mw);
    string p;
    p = (d == 0) ? "dut0" : "dut1";
    checkOutput({p, ".condExQ"},   32'(condQ),    32'(mCondQ[d]));
    checkOutput({p, ".flagsOut"},  32'(flagsOut), 32'(committedFlags(d)));
    checkOutput({p, ".squashCnt"}, cnt,           32'(mCnt[d]));
    checkOutput({p, ".pcWrite"},   32'(pcw),      32'(sNextPc | (sPcs & mCondQ[d])));
    checkOutput({p, ".regWrite"},  32'(rw),       32'(sRegW & mCondQ[d]));
    checkOutput({p, ".memWrite"},  32'(mw),       32'(sMemW & mCondQ[d]));
  endtask

  task automatic compareAll();
    checkDut(0, if0.o_condExQ, if0.o_flagsOut, 32'(if0.o_squashCnt), if0.o_pcWrite, if0.o_regWrite, if0.o_memWrite);
    checkDut(1, if1.o_condExQ, if1.o_flagsOut, 32'(if1.o_squashCnt), if1.o_pcWrite, if1.o_regWrite, if1.o_memWrite);
  endtask

  // Inputs are applied just after a falling edge; outputs are sampled on the next falling edge.
  task automatic cycle(input bit pulseReset);
    @(posedge clk);
    modelStep();
    if (pulseReset) begin
      #2 rst_n = 1'b0;
      modelReset();
      #1 rst_n = 1'b1;
    end
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input int bank);
    applyStimulus(4'b1110, 4'b0000, 2'b00, bank, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    modelReset();
    applyStimulus(4'b1110, 4'b0000, 2'b00, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #3;
    compareAll();
    checkOutput("reset.pcWrite", 32'(if0.o_pcWrite), 32'd1);
    checkOutput("reset.regWrite", 32'(if0.o_regWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'b0000, 4'b0000, 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    checkOutput("eqFail.condExQ", 32'(if0.o_condExQ), 32'd0);
    checkOutput("eqFail.squash", 32'(if0.o_squashCnt), 32'd1);
    applyStimulus(4'b1110, 4'b0000, 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    applyStimulus(4'b0000, 4'b0000, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); cycle(0);
    checkOutput("al.regWrite", 32'(if0.o_regWrite), 32'd1);

    applyStimulus(4'b0000, 4'b0100, 2'b11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    checkOutput("pending.flagsOut", 32'(if0.o_flagsOut), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    checkOutput("forward.condExQ", 32'(if0.o_condExQ), 32'd1);
    checkOutput("commit.flagsOut", 32'(if0.o_flagsOut), 32'h4);

    applyStimulus(4'b0000, 4'b1111, 2'b01, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    idle(0); cycle(0);
    checkOutput("cvOnly.flagsOut", 32'(if0.o_flagsOut), 32'h7);

    applyStimulus(4'b0001, 4'b0000, 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    applyStimulus(4'b0000, 4'b1010, 2'b11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    idle(0); cycle(0);
    checkOutput("gatedWrite.flagsOut", 32'(if0.o_flagsOut), 32'h7);
    applyStimulus(4'b1110, 4'b0000, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checkOutput("pcsSquashed.pcWrite", 32'(if0.o_pcWrite), 32'd0);
    applyStimulus(4'b1110, 4'b0000, 2'b00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    checkOutput("nextPc.pcWrite", 32'(if0.o_pcWrite), 32'd1);
    cycle(0);

    applyStimulus(4'b1110, 4'b0000, 2'b00, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    applyStimulus(4'b1110, 4'b1000, 2'b11, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    idle(2); cycle(0);
    checkOutput("bank2.flagsOut", 32'(if0.o_flagsOut), 32'h8);
    applyStimulus(4'b0100, 4'b0000, 2'b00, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    checkOutput("bank1MI.condExQ", 32'(if0.o_condExQ), 32'd0);
    applyStimulus(4'b0100, 4'b0000, 2'b00, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    checkOutput("bank2MI.condExQ", 32'(if0.o_condExQ), 32'd1);
    applyStimulus(4'b0100, 4'b0000, 2'b00, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checkOutput("bank7.flagsOut", 32'(if0.o_flagsOut), 32'h0);
    cycle(0);
    applyStimulus(4'b0000, 4'b0000, 2'b00, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    checkOutput("saturate.squash", 32'(if0.o_squashCnt), 32'd3);

    applyStimulus(4'b1110, 4'b0000, 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle(0);
    applyStimulus(4'b1110, 4'b1111, 2'b11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle(1);
    idle(0); cycle(0);
    checkOutput("lostPending.flagsOut", 32'(if0.o_flagsOut), 32'h0);
    checkOutput("lostPending.squash", 32'(if0.o_squashCnt), 32'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle($urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
